// File: rtl/znz_stream_decoder.sv
// Zero/non-zero stream decoder: expands a ZNZ bitmap plus packed non-zero elements
// into a dense vector, realigning narrow encoded beats through a residue buffer.
module znz_stream_decoder #(
  parameter int ZNZ_BITS  = 128,
  parameter int DATA_W    = 8,
  parameter int DIN_BYTES = 32,
  parameter int CNT_W     = $clog2(ZNZ_BITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ZNZ_BITS-1:0]           znz_din,
  input  logic                          znz_last,
  input  logic                          znz_vld,
  output logic                          znz_rdy,
  input  logic [DIN_BYTES*DATA_W-1:0]   enc_din,
  input  logic                          enc_vld,
  output logic                          enc_rdy,
  output logic [ZNZ_BITS*DATA_W-1:0]    dec_dout,
  output logic [CNT_W-1:0]              dec_nnz,
  output logic                          dec_last,
  output logic                          dec_vld,
  input  logic                          dec_rdy,
  output logic                          err_pad
);
  localparam int BUF_ELEMS = ZNZ_BITS + DIN_BYTES;
  localparam int LVL_W     = $clog2(BUF_ELEMS + 1);

  typedef logic [BUF_ELEMS-1:0][DATA_W-1:0] buf_t;

  buf_t                      buf_q, buf_n, shifted, ext, mask;
  logic [LVL_W-1:0]          lvl, lvl_n, pop, shamt, base;
  logic [LVL_W-1:0]          prefix [ZNZ_BITS];
  logic [ZNZ_BITS*DATA_W-1:0] dout_n;
  logic                      out_free, fire, accept;

  // prefix[i] is the buffer slot holding element i when bit i is set
  always_comb begin
    pop = '0;
    for (int i = 0; i < ZNZ_BITS; i++) begin
      prefix[i] = pop;
      pop       = pop + LVL_W'(znz_din[i]);
    end
  end

  assign out_free = !dec_vld || dec_rdy;
  assign fire     = znz_vld && out_free && (pop <= lvl);
  assign znz_rdy  = fire;
  // Hold beats while a tile-final bitmap is pending so next-tile data is never discarded
  assign enc_rdy  = (lvl <= LVL_W'(ZNZ_BITS)) && !(znz_vld && znz_last);
  assign accept   = enc_vld && enc_rdy;
  assign shamt    = (fire && !znz_last) ? pop : '0;
  assign base     = lvl - shamt;

  always_comb begin
    shifted             = buf_q >> (int'(shamt) * DATA_W);
    ext                 = '0;
    mask                = '0;
    ext[DIN_BYTES-1:0]  = enc_din;
    mask[DIN_BYTES-1:0] = '1;
    ext                 = ext << (int'(base) * DATA_W);
    mask                = mask << (int'(base) * DATA_W);
    buf_n               = accept ? ((shifted & ~mask) | ext) : shifted;
    if (fire && znz_last)
      lvl_n = '0;
    else
      lvl_n = base + (accept ? LVL_W'(DIN_BYTES) : '0);
  end

  always_comb begin
    dout_n = '0;
    for (int i = 0; i < ZNZ_BITS; i++)
      dout_n[i*DATA_W +: DATA_W] = znz_din[i] ? buf_q[prefix[i]] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl      <= '0;
      buf_q    <= '0;
      dec_vld  <= 1'b0;
      dec_dout <= '0;
      dec_nnz  <= '0;
      dec_last <= 1'b0;
      err_pad  <= 1'b0;
    end else begin
      lvl   <= lvl_n;
      buf_q <= buf_n;
      if (fire) begin
        dec_vld  <= 1'b1;
        dec_dout <= dout_n;
        dec_nnz  <= CNT_W'(pop);
        dec_last <= znz_last;
      end else if (dec_rdy) begin
        dec_vld <= 1'b0;
      end
      if (fire && znz_last && ((lvl - pop) >= LVL_W'(DIN_BYTES)))
        err_pad <= 1'b1;
    end
  end

  lvl_bound: assert property (@(posedge clk) disable iff (!rst_n) lvl <= LVL_W'(BUF_ELEMS));

endmodule

// File: tb/tb_znz_stream_decoder.sv
// Scoreboard bench for znz_stream_decoder at ZNZ_BITS=8, DATA_W=8, DIN_BYTES=4.
module tb_znz_stream_decoder;
  localparam int ZB = 8;
  localparam int DW = 8;
  localparam int DB = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [ZB*DW-1:0] dout;
    logic [CW-1:0]    nnz;
    logic             last;
  } out_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [ZB-1:0]    znz_din = '0;
  logic             znz_last = 1'b0, znz_vld = 1'b0, znz_rdy;
  logic [DB*DW-1:0] enc_din = '0;
  logic             enc_vld = 1'b0, enc_rdy;
  logic [ZB*DW-1:0] dec_dout;
  logic [CW-1:0]    dec_nnz;
  logic             dec_last, dec_vld, err_pad;
  logic             dec_rdy = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]    stream_q[$];
  out_t             exp_q[$], got_q[$];
  logic [DB*DW-1:0] beat_q[$];
  logic [ZB:0]      bmp_q[$];
  int               fire_cyc[$], acc_cyc[$], hs_cyc[$];
  int               hold_cyc, hold_viol;
  bit               enc_low, timed_out, exp_err;

  znz_stream_decoder #(.ZNZ_BITS(ZB), .DATA_W(DW), .DIN_BYTES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .znz_din(znz_din), .znz_last(znz_last), .znz_vld(znz_vld), .znz_rdy(znz_rdy),
    .enc_din(enc_din), .enc_vld(enc_vld), .enc_rdy(enc_rdy),
    .dec_dout(dec_dout), .dec_nnz(dec_nnz), .dec_last(dec_last), .dec_vld(dec_vld),
    .dec_rdy(dec_rdy), .err_pad(err_pad)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream-level model: elements are consumed in order; a tile end drops the rest
  task automatic model_beat(input logic [DB*DW-1:0] b);
    for (int k = 0; k < DB; k++) stream_q.push_back(b[k*DW +: DW]);
    beat_q.push_back(b);
  endtask

  task automatic model_bitmap(input logic [ZB-1:0] bm, input logic last);
    out_t e;
    e = '0;
    for (int i = 0; i < ZB; i++) begin
      if (bm[i]) begin
        if (stream_q.size() > 0) e.dout[i*DW +: DW] = stream_q.pop_front();
        e.nnz = e.nnz + 1'b1;
      end
    end
    e.last = last;
    if (last) begin
      if (stream_q.size() >= DB) exp_err = 1'b1;
      stream_q.delete();
    end
    exp_q.push_back(e);
    bmp_q.push_back({last, bm});
  endtask

  task automatic run(input int max_cyc, input int stall);
    out_t prev, cur;
    bit   prev_hold;
    int   cyc;
    fire_cyc.delete(); acc_cyc.delete(); hs_cyc.delete(); got_q.delete();
    hold_cyc = 0; hold_viol = 0; enc_low = 0; timed_out = 0;
    prev = '0; prev_hold = 0; cyc = 0;
    while (beat_q.size() > 0 || bmp_q.size() > 0 || dec_vld) begin
      if (cyc >= max_cyc) begin
        timed_out = 1;
        break;
      end
      enc_vld = (beat_q.size() > 0);
      enc_din = enc_vld ? beat_q[0] : '0;
      znz_vld = (bmp_q.size() > 0);
      {znz_last, znz_din} = znz_vld ? bmp_q[0] : '0;
      dec_rdy = (cyc >= stall);
      #1;
      cur = {dec_dout, dec_nnz, dec_last};
      if (enc_vld && !enc_rdy) enc_low = 1;
      if (prev_hold && cur !== prev) hold_viol++;
      if (dec_vld && !dec_rdy) begin
        hold_cyc++;
        if (znz_rdy) hold_viol++;
      end
      prev_hold = dec_vld && !dec_rdy;
      prev = cur;
      if (enc_vld && enc_rdy) begin acc_cyc.push_back(cyc); void'(beat_q.pop_front()); end
      if (znz_vld && znz_rdy) begin fire_cyc.push_back(cyc); void'(bmp_q.pop_front()); end
      if (dec_vld && dec_rdy) begin hs_cyc.push_back(cyc); got_q.push_back(cur); end
      tick();
      cyc++;
    end
    enc_vld = 0; znz_vld = 0; znz_last = 0; znz_din = '0; enc_din = '0; dec_rdy = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; dec_rdy = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    checks++; if (dec_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", dec_vld); end
    checks++; if (dec_dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dec_dout); end
    checks++; if (dec_nnz !== '0) begin failures++; $display("FAIL reset_nnz got=%0d exp=0", dec_nnz); end
    checks++; if (dec_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", dec_last); end
    checks++; if (err_pad !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_pad); end
    checks++; if (dut.lvl !== '0) begin failures++; $display("FAIL reset_lvl got=%0d exp=0", dut.lvl); end
    checks++; if (enc_rdy !== 1'b1) begin failures++; $display("FAIL reset_enc_rdy got=%b exp=1", enc_rdy); end
    checks++; if (znz_rdy !== 1'b0) begin failures++; $display("FAIL reset_znz_rdy got=%b exp=0", znz_rdy); end
  endtask

  task automatic test_basic();
    model_beat(32'h44332211);
    model_bitmap(8'h05, 1'b0);
    run(20, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      out_t g = got_q.pop_front();
      out_t e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL basic_out got=%h/%0d/%b exp=%h/%0d/%b", g.dout, g.nnz, g.last, e.dout, e.nnz, e.last); end
    end
    exp_q.delete();
    checks++; if (acc_cyc.size() != 1 || fire_cyc.size() != 1 || fire_cyc[0] != 1) begin failures++; $display("FAIL basic_fire_cycle got=%0d exp=1", fire_cyc.size() > 0 ? fire_cyc[0] : -1); end
    checks++; if (hs_cyc.size() != 1 || hs_cyc[0] != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", hs_cyc.size() > 0 ? hs_cyc[0] : -1); end
    checks++; if (dut.lvl !== 4'd2) begin failures++; $display("FAIL basic_lvl got=%0d exp=2", dut.lvl); end
  endtask

  task automatic test_straddle();
    model_beat(32'h58575655);
    model_beat(32'h5C5B5A59);
    model_bitmap(8'hFF, 1'b0);
    run(20, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL straddle_timeout got=1 exp=0"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL straddle_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      out_t g = got_q.pop_front();
      out_t e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL straddle_out got=%h/%0d/%b exp=%h/%0d/%b", g.dout, g.nnz, g.last, e.dout, e.nnz, e.last); end
    end
    exp_q.delete();
    checks++; if (acc_cyc.size() != 2 || fire_cyc.size() != 1 || fire_cyc[0] != 2) begin failures++; $display("FAIL straddle_fire_cycle got=%0d exp=2", fire_cyc.size() > 0 ? fire_cyc[0] : -1); end
    checks++; if (dut.lvl !== 4'd2) begin failures++; $display("FAIL straddle_lvl got=%0d exp=2", dut.lvl); end
  endtask

  task automatic test_zero_bitmap();
    model_bitmap(8'h03, 1'b0);
    run(20, 0);
    checks++; if (dut.lvl !== 4'd0) begin failures++; $display("FAIL drain_lvl got=%0d exp=0", dut.lvl); end
    model_bitmap(8'h00, 1'b0);
    run(20, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL zero_timeout got=1 exp=0"); end
    checks++; if (fire_cyc.size() != 1 || fire_cyc[0] != 0) begin failures++; $display("FAIL zero_fire_cycle got=%0d exp=0", fire_cyc.size() > 0 ? fire_cyc[0] : -1); end
    checks++; if (hs_cyc.size() != 1 || hs_cyc[0] != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", hs_cyc.size() > 0 ? hs_cyc[0] : -1); end
    // Scoreboard still holds the drain result ahead of the zero vector
    checks++; if (exp_q.size() != 2 || got_q.size() != 1) begin failures++; $display("FAIL zero_count got=%0d exp=1", got_q.size()); end
    if (exp_q.size() == 2) void'(exp_q.pop_front());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      out_t g = got_q.pop_front();
      out_t e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL zero_out got=%h/%0d/%b exp=%h/%0d/%b", g.dout, g.nnz, g.last, e.dout, e.nnz, e.last); end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    model_beat(32'h13121110);
    model_beat(32'h17161514);
    model_beat(32'h1B1A1918);
    model_beat(32'h1F1E1D1C);
    model_beat(32'h23222120);
    model_bitmap(8'h0F, 1'b0);
    model_bitmap(8'hF0, 1'b0);
    model_bitmap(8'hFF, 1'b0);
    model_bitmap(8'h0F, 1'b0);
    run(60, 5);
    checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL bp_hold_stable got=%0d exp=0", hold_viol); end
    checks++; if (hold_cyc != 3) begin failures++; $display("FAIL bp_hold_cycles got=%0d exp=3", hold_cyc); end
    checks++; if (!enc_low) begin failures++; $display("FAIL bp_enc_rdy_drop got=0 exp=1"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < hs_cyc.size(); i++) begin
      checks++; if (hs_cyc[i] != 5 + i) begin failures++; $display("FAIL bp_b2b idx=%0d got=%0d exp=%0d", i, hs_cyc[i], 5 + i); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      out_t g = got_q.pop_front();
      out_t e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL bp_out got=%h/%0d/%b exp=%h/%0d/%b", g.dout, g.nnz, g.last, e.dout, e.nnz, e.last); end
    end
    exp_q.delete();
    checks++; if (dut.lvl !== 4'd0) begin failures++; $display("FAIL bp_lvl got=%0d exp=0", dut.lvl); end
  endtask

  task automatic test_tile_end();
    model_beat(32'hA4A3A2A1);
    run(20, 0);
    checks++; if (dut.lvl !== 4'd4) begin failures++; $display("FAIL tile_pre_lvl got=%0d exp=4", dut.lvl); end
    model_bitmap(8'h01, 1'b1);
    model_beat(32'hB4B3B2B1);
    run(20, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL tile_timeout got=1 exp=0"); end
    checks++; if (fire_cyc.size() != 1 || fire_cyc[0] != 0) begin failures++; $display("FAIL tile_fire_cycle got=%0d exp=0", fire_cyc.size() > 0 ? fire_cyc[0] : -1); end
    checks++; if (acc_cyc.size() != 1 || acc_cyc[0] != 1 || !enc_low) begin failures++; $display("FAIL tile_beat_held got=%0d exp=1", acc_cyc.size() > 0 ? acc_cyc[0] : -1); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL tile_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      out_t g = got_q.pop_front();
      out_t e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL tile_out got=%h/%0d/%b exp=%h/%0d/%b", g.dout, g.nnz, g.last, e.dout, e.nnz, e.last); end
    end
    exp_q.delete();
    checks++; if (err_pad !== exp_err) begin failures++; $display("FAIL tile_err got=%b exp=%b", err_pad, exp_err); end
    checks++; if (dut.lvl !== 4'd4) begin failures++; $display("FAIL tile_post_lvl got=%0d exp=4", dut.lvl); end
  endtask

  task automatic test_excess_pad();
    model_beat(32'hC4C3C2C1);
    model_bitmap(8'h07, 1'b0);
    run(20, 0);
    checks++; if (dut.lvl !== 4'd5) begin failures++; $display("FAIL excess_pre_lvl got=%0d exp=5", dut.lvl); end
    model_bitmap(8'h01, 1'b1);
    run(20, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL excess_timeout got=1 exp=0"); end
    checks++; if (got_q.size() != 1 || exp_q.size() != 2) begin failures++; $display("FAIL excess_count got=%0d exp=1", got_q.size()); end
    if (exp_q.size() == 2) void'(exp_q.pop_front());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      out_t g = got_q.pop_front();
      out_t e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL excess_out got=%h/%0d/%b exp=%h/%0d/%b", g.dout, g.nnz, g.last, e.dout, e.nnz, e.last); end
    end
    exp_q.delete();
    checks++; if (err_pad !== exp_err) begin failures++; $display("FAIL excess_err got=%b exp=%b", err_pad, exp_err); end
    checks++; if (dut.lvl !== 4'd0) begin failures++; $display("FAIL excess_lvl got=%0d exp=0", dut.lvl); end
    repeat (3) tick();
    checks++; if (err_pad !== exp_err) begin failures++; $display("FAIL excess_sticky got=%b exp=%b", err_pad, exp_err); end
  endtask

  task automatic test_reset_mid();
    dec_rdy = 0;
    enc_din = 32'hD4D3D2D1; enc_vld = 1; tick();
    enc_din = 32'hE4E3E2E1; tick();
    enc_vld = 0; znz_din = 8'h01; znz_last = 0; znz_vld = 1; tick();
    znz_vld = 0; znz_din = '0; tick();
    checks++; if (dec_vld !== 1'b1 || dut.lvl !== 4'd7) begin failures++; $display("FAIL mid_setup got=%b/%0d exp=1/7", dec_vld, dut.lvl); end
    #2 rst_n = 0;
    #1;
    checks++; if (dec_vld !== 1'b0) begin failures++; $display("FAIL mid_reset_vld got=%b exp=0", dec_vld); end
    checks++; if (err_pad !== 1'b0) begin failures++; $display("FAIL mid_reset_err got=%b exp=0", err_pad); end
    checks++; if (dut.lvl !== 4'd0) begin failures++; $display("FAIL mid_reset_lvl got=%0d exp=0", dut.lvl); end
    checks++; if (dec_dout !== '0) begin failures++; $display("FAIL mid_reset_dout got=%h exp=0", dec_dout); end
    tick();
    rst_n = 1; dec_rdy = 1;
    stream_q.delete(); exp_q.delete(); beat_q.delete(); bmp_q.delete(); exp_err = 0;
    model_beat(32'hF4F3F2F1);
    model_bitmap(8'h02, 1'b0);
    run(20, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL cold_timeout got=1 exp=0"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL cold_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      out_t g = got_q.pop_front();
      out_t e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL cold_out got=%h/%0d/%b exp=%h/%0d/%b", g.dout, g.nnz, g.last, e.dout, e.nnz, e.last); end
    end
    exp_q.delete();
    checks++; if (dut.lvl !== 4'd3 || err_pad !== 1'b0) begin failures++; $display("FAIL cold_state got=%0d/%b exp=3/0", dut.lvl, err_pad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_straddle();
    test_zero_bitmap();
    test_backpressure();
    test_tile_end();
    test_excess_pad();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/znz_stream_decoder.md
Name: znz_stream_decoder

Overview:
Second-generation zero/non-zero (ZNZ) decoder. It expands one ZNZ bitmap plus a packed stream of non-zero elements into one dense output vector. Encoded data arrives in beats of DIN_BYTES elements, narrower than ZNZ_BITS. The non-zero elements of consecutive bitmaps are packed back-to-back, so a beat may straddle bitmap boundaries. An internal residue buffer realigns the stream, and per-tile end-of-tile handling discards padding.

Parameters:
ZNZ_BITS, 128, bits per bitmap = elements per decoded vector
DATA_W, 8, element width in bits
DIN_BYTES, 32, elements per encoded beat; legal range 1..ZNZ_BITS
BUF_ELEMS, ZNZ_BITS+DIN_BYTES, residue buffer capacity in elements (derived, not overridable)
CNT_W, $clog2(ZNZ_BITS+1), width of the element count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
znz_din  in  ZNZ_BITS  bitmap; bit i=1 means element i is non-zero
znz_last  in  1  bitmap is the last of a tile
znz_vld  in  1  bitmap valid
znz_rdy  out  1  bitmap consumed this cycle
enc_din  in  DIN_BYTES*DATA_W  packed beat; element k in bits [(k+1)*DATA_W-1 : k*DATA_W], k=0 oldest
enc_vld  in  1  beat valid
enc_rdy  out  1  beat accepted when enc_vld && enc_rdy
dec_dout  out  ZNZ_BITS*DATA_W  dense vector; element i in bits [(i+1)*DATA_W-1 : i*DATA_W]
dec_nnz  out  CNT_W  popcount of the source bitmap
dec_last  out  1  copy of znz_last of the source bitmap
dec_vld  out  1  output valid
dec_rdy  in  1  output ready
err_pad  out  1  sticky: padding discarded at tile end was >= DIN_BYTES elements

Behaviour:
- Reset (async, rst_n=0): lvl=0, buffer contents don't-care, dec_vld=0, dec_dout=0, dec_nnz=0, dec_last=0, err_pad=0.
- Reset mid-operation drops all buffered and in-flight data. The first cycle after reset behaves as a cold start.
- Buffer: BUF_ELEMS entries; lvl counts valid elements; entry 0 is oldest.
- Definitions: pop = popcount(znz_din); out_free = !dec_vld || dec_rdy.
- fire = znz_vld && out_free && (pop <= lvl). znz_rdy = fire (combinational).
- A bitmap is consumed only when all of its elements are already registered in the buffer. Data accepted in the same cycle is never used.
- enc_rdy = (lvl <= ZNZ_BITS) && !(znz_vld && znz_last). This holds beats back while a tile-final bitmap is pending, so next-tile data is never discarded.
- On fire, the registered output loads, so dec_vld rises the next cycle (latency 1):
  - dec_dout element i = bit i ? buffer[prefix_i] : 0, where prefix_i = popcount(znz_din[i-1:0]).
  - dec_nnz = pop; dec_last = znz_last.
- Buffer update, non-last fire: shift down by pop; lvl_next = lvl - pop.
- Buffer update, last fire: lvl_next = 0; all residue is discarded as padding. err_pad sets if (lvl - pop) >= DIN_BYTES.
- Beat accept: the beat is appended at position (lvl - (fire ? pop : 0)); lvl increases by DIN_BYTES.
  - A non-last fire and an accept in the same cycle are both applied.
  - An accept never coincides with a last fire, because enc_rdy is 0 then.
- Output hold: while dec_vld && !dec_rdy, all dec_* are stable and no fire occurs.
- Output drain: dec_vld falls after a handshake when there is no fire in that cycle. Fire in the handshake cycle gives back-to-back outputs at full rate.
- pop=0 bitmap: fires with lvl=0 and produces an all-zero vector with nnz=0.
- Overflow impossible: accept only when lvl <= ZNZ_BITS, so lvl <= BUF_ELEMS always. Implement an assertion on lvl > BUF_ELEMS.
- Throughput: one bitmap per cycle when the buffer holds enough data. A dense bitmap (pop=ZNZ_BITS) needs ceil(ZNZ_BITS/DIN_BYTES) beats.
- err_pad clears only on reset.
- Arithmetic: lvl width $clog2(BUF_ELEMS+1). The prefix popcount is computed combinationally for all i.

Test Plan (ZNZ_BITS=8, DATA_W=8, DIN_BYTES=4, BUF_ELEMS=12):
- Basic decode: beat {0x44,0x33,0x22,0x11}, then bitmap 8'h05 -> one cycle after fire, dout = {0,0,0,0,0,0x22,0,0x11}, nnz=2; lvl=2 with 0x33,0x44 retained.
- Beat straddle: continue from the basic case with bitmap 8'hFF and two beats 0x55..0x58, 0x59..0x5C -> fire only after both beats are registered; dout elements 0..7 = 0x33,0x44,0x55..0x5A, nnz=8; lvl=2.
- Zero bitmap, no encoded data, lvl=0: bitmap 8'h00 -> fires immediately; dout=0, nnz=0; next cycle dec_vld=1.
- Backpressure: dec_rdy=0 for 5 cycles with bitmaps and beats streaming -> dec_* stable, znz_rdy=0 throughout. enc_rdy drops once lvl reaches 12. After dec_rdy=1, outputs emerge back-to-back in order.
- Tile end, legal padding: znz_last with bitmap 8'h01 and lvl=4 -> 3 elements discarded, lvl=0, err_pad=0, dec_last=1. Next-tile beat held (enc_rdy=0) until fire, then accepted.
- Tile end, excess padding and reset: same scenario with lvl=5 -> err_pad=1 and stays set. Then assert rst_n mid-stream -> dec_vld=0, err_pad=0, lvl=0 immediately.
